mips_run_ctrl: RTL and testbench



---
 rtl/mips_run_ctrl_if.sv | 27 ++
 rtl/mips_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_mips_run_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mips_run_ctrl_if.sv
// Run-control bus between the MIPS test harness and mips_run_ctrl.
// The harness side drives start/pc/halt_addr; the controller drives status.
interface mips_run_ctrl_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  halt_addr;
    logic                 dut_reset;
    logic                 running;
    logic                 done;
    logic                 pass;
    logic                 stalled;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output start, pc, halt_addr,
        input  dut_reset, running, done, pass, stalled, timeout, cycle_count
    );

    modport slave (
        input  start, pc, halt_addr,
        output dut_reset, running, done, pass, stalled, timeout, cycle_count
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// Deterministic run controller for the single-cycle MIPS harness: holds the DUT
// in reset, runs it, and ends on halt-address match, PC stall or timeout.
module mips_run_ctrl #(
    parameter int PC_WIDTH       = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HALT_REPEAT    = 3
) (
    input  logic            clk,
    input  logic            reset,
    mips_run_ctrl_if.slave  bus
);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;

    localparam logic [RW-1:0]        RST_LOAD   = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0]        STALL_LAST = SW'(HALT_REPEAT - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RST_DUT,
        RUN,
        DONE
    } state_t;

    state_t               state, state_nx;

    logic [RW-1:0]        rst_cnt, rst_cnt_d;
    logic [SW-1:0]        stall_cnt, stall_cnt_d;
    logic                 valid, valid_d;
    logic [PC_WIDTH-1:0]  pc_prev, pc_prev_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;
    logic                 dut_reset_q, running_q, done_q;
    logic                 dut_reset_d, running_d, done_d;
    logic                 pass_q, stalled_q, timeout_q;
    logic                 pass_d, stalled_d, timeout_d;

    logic pc_match, halt_hit, stall_hit, time_hit, run_end;

    assign pc_match  = valid && (bus.pc == pc_prev);
    assign halt_hit  = (bus.pc == bus.halt_addr);
    assign stall_hit = pc_match && (stall_cnt == STALL_LAST);
    assign time_hit  = (cnt == TO_LAST);
    assign run_end   = halt_hit || stall_hit || time_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            stall_cnt   <= '0;
            valid       <= 1'b0;
            pc_prev     <= '0;
            cnt         <= '0;
            dut_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            stalled_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            rst_cnt     <= rst_cnt_d;
            stall_cnt   <= stall_cnt_d;
            valid       <= valid_d;
            pc_prev     <= pc_prev_d;
            cnt         <= cnt_d;
            dut_reset_q <= dut_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            stalled_q   <= stalled_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start)       state_nx = RST_DUT;
            RST_DUT: if (rst_cnt == '0)   state_nx = RUN;
            RUN:     if (run_end)         state_nx = DONE;
            DONE:    if (bus.start)       state_nx = RST_DUT;
            default:                      state_nx = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they land in flops
    // on the same edge as the transition that sets them.
    always_comb begin
        rst_cnt_d   = rst_cnt;
        stall_cnt_d = stall_cnt;
        valid_d     = valid;
        pc_prev_d   = pc_prev;
        cnt_d       = cnt;
        pass_d      = pass_q;
        stalled_d   = stalled_q;
        timeout_d   = timeout_q;
        dut_reset_d = (state_nx == IDLE) || (state_nx == RST_DUT);
        running_d   = (state_nx == RUN);
        done_d      = (state_nx == DONE);

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    rst_cnt_d = RST_LOAD;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    stalled_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RST_DUT: begin
                if (rst_cnt != '0) begin
                    rst_cnt_d = rst_cnt - 1'b1;
                end else begin
                    valid_d     = 1'b0;
                    stall_cnt_d = '0;
                end
            end
            RUN: begin
                cnt_d       = cnt + 1'b1;
                pc_prev_d   = bus.pc;
                valid_d     = 1'b1;
                stall_cnt_d = pc_match ? stall_cnt + 1'b1 : '0;
                // First match wins: halt, then stall, then timeout.
                if (halt_hit)       pass_d    = 1'b1;
                else if (stall_hit) stalled_d = 1'b1;
                else if (time_hit)  timeout_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.dut_reset   = dut_reset_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.stalled     = stalled_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cnt;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: three instances with different timeouts
// share one stimulus stream; each phase checks the instance it targets.
module tb_mips_run_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] halt_addr;
    logic [31:0] pcs [16];

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    // {dut_reset, running, done, pass, stalled, timeout}
    localparam logic [5:0] S_IDLE  = 6'b100000;
    localparam logic [5:0] S_RUN   = 6'b010000;
    localparam logic [5:0] S_PASS  = 6'b001100;
    localparam logic [5:0] S_STALL = 6'b001010;
    localparam logic [5:0] S_TO    = 6'b001001;

    mips_run_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) ifa ();
    mips_run_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) ifb ();
    mips_run_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) ifc ();

    assign ifa.start = start;  assign ifa.pc = pc;  assign ifa.halt_addr = halt_addr;
    assign ifb.start = start;  assign ifb.pc = pc;  assign ifb.halt_addr = halt_addr;
    assign ifc.start = start;  assign ifc.pc = pc;  assign ifc.halt_addr = halt_addr;

    mips_run_ctrl dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mips_run_ctrl #(.TIMEOUT_CYCLES(10)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    mips_run_ctrl #(.TIMEOUT_CYCLES(5))  dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [5:0] sta, stb, stc;
    assign sta = {ifa.dut_reset, ifa.running, ifa.done, ifa.pass, ifa.stalled, ifa.timeout};
    assign stb = {ifb.dut_reset, ifb.running, ifb.done, ifb.pass, ifb.stalled, ifb.timeout};
    assign stc = {ifc.dut_reset, ifc.running, ifc.done, ifc.pass, ifc.stalled, ifc.timeout};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Start edge plus three more hold dut_reset; the fourth releases into RUN.
    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        chk_st("rst_dut_entry", sta, S_IDLE);
        chk_cnt("rst_dut_cnt", ifa.cycle_count, 16'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_st("rst_dut_hold", sta, S_IDLE);
        end
        step();
        chk_st("run_entry", sta, S_RUN);
        chk_cnt("run_entry_cnt", ifa.cycle_count, 16'd0);
    endtask

    task automatic drive(input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            pc = pcs[k];
            step();
        end
    endtask

    task automatic fill_incr();
        for (int k = 0; k < 16; k++) pcs[k] = 32'(4 * k);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pc = '0;
        halt_addr = '0;
        fill_incr();

        step();
        step();
        chk_st("reset_a", sta, S_IDLE);
        chk_st("reset_b", stb, S_IDLE);
        chk_st("reset_c", stc, S_IDLE);
        chk_cnt("reset_cnt", ifa.cycle_count, 16'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_st("idle_hold", sta, S_IDLE);
        end
        chk_cnt("idle_cnt", ifa.cycle_count, 16'd0);

        // Normal halt at 0x20 on RUN cycle 9
        halt_addr = 32'h20;
        start_run();
        drive(0, 8);
        chk_st("halt_pre", sta, S_RUN);
        chk_cnt("halt_pre_cnt", ifa.cycle_count, 16'd8);
        drive(8, 9);
        chk_st("halt_pass", sta, S_PASS);
        chk_cnt("halt_cnt", ifa.cycle_count, 16'd9);
        chk_st("halt_c_timeout", stc, S_TO);
        chk_cnt("halt_c_cnt", ifc.cycle_count, 16'd5);
        step();
        step();
        chk_st("done_hold", sta, S_PASS);
        chk_cnt("done_hold_cnt", ifa.cycle_count, 16'd9);

        // Stall: 0,4,8,8,8,8
        pulse_reset();
        halt_addr = 32'h100;
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        pcs[3] = 32'h8; pcs[4] = 32'h8; pcs[5] = 32'h8;
        start_run();
        drive(0, 5);
        chk_st("stall_pre", sta, S_RUN);
        chk_cnt("stall_pre_cnt", ifa.cycle_count, 16'd5);
        drive(5, 6);
        chk_st("stall", sta, S_STALL);
        chk_cnt("stall_cnt", ifa.cycle_count, 16'd6);
        chk_st("stall_c_timeout", stc, S_TO);

        // Timeout on the 10-cycle instance
        pulse_reset();
        fill_incr();
        halt_addr = 32'h1000;
        start_run();
        drive(0, 9);
        chk_st("to_pre", stb, S_RUN);
        chk_cnt("to_pre_cnt", ifb.cycle_count, 16'd9);
        drive(9, 10);
        chk_st("timeout", stb, S_TO);
        chk_cnt("timeout_cnt", ifb.cycle_count, 16'd10);
        chk_st("timeout_a_run", sta, S_RUN);

        // Halt and timeout on the same edge: halt wins
        pulse_reset();
        halt_addr = 32'h10;
        start_run();
        drive(0, 5);
        chk_st("prio", stc, S_PASS);
        chk_cnt("prio_cnt", ifc.cycle_count, 16'd5);

        // Reset during RUN cycle 3
        pulse_reset();
        halt_addr = 32'h1000;
        start_run();
        drive(0, 2);
        pc = 32'h8;
        reset = 1'b0;
        step();
        chk_st("midrun_reset", sta, S_IDLE);
        chk_cnt("midrun_cnt", ifa.cycle_count, 16'd0);
        reset = 1'b1;

        // Pass, then restart from DONE with a new halt address
        halt_addr = 32'h20;
        start_run();
        drive(0, 9);
        chk_st("restart_first", sta, S_PASS);
        halt_addr = 32'h8;
        start_run();
        drive(0, 3);
        chk_st("restart_pass", sta, S_PASS);
        chk_cnt("restart_cnt", ifa.cycle_count, 16'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
